// File: rtl/freq_preset_sequencer.sv
// Push-button preset sequencer for the NCO tuning path: synchronises and debounces three
// buttons, steps through a table of tuning words and presents them to the NCO loader.
module freq_preset_sequencer #(
   parameter int                           FTW_W          = 44,
   parameter int                           NUM_PRESETS    = 2,
   parameter logic [NUM_PRESETS*FTW_W-1:0] PRESETS        = {44'hCC4EEB76301, 44'hE12EAA86301},
   parameter int                           DEBOUNCE_CYC   = 1_000_000,
   parameter int                           SYNC_STAGES    = 2,
   parameter bit                           HOLD_UNTIL_ACK = 1'b0,
   localparam int                          IDX_W          = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             btn_next,
   input  logic             btn_prev,
   input  logic             btn_clr,
   input  logic             NewDataAck,
   output logic [FTW_W-1:0] FreqData,
   output logic             NewDataReady,
   output logic [IDX_W-1:0] preset_idx,
   output logic             busy,
   output logic [1:0]       fsm_state_o
);

   localparam int             CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ACK = 2'd2
   } state_e;

   // Button order in the vectors below: bit 0 next, bit 1 prev, bit 2 clr.
   logic [2:0] btn_raw;
   logic [2:0] press_ev;

   assign btn_raw = {btn_clr, btn_prev, btn_next};

   for (genvar b = 0; b < 3; b++) begin : g_btn
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CNT_W-1:0]       cnt_q;
      logic                   deb_q;
      logic                   deb_dly_q;
      logic                   ev_q;
      logic                   synced;

      assign synced      = sync_q[SYNC_STAGES-1];
      assign press_ev[b] = ev_q;

      // The counter only advances while the synced level disagrees with the accepted level,
      // so any bounce shorter than DEBOUNCE_CYC restarts the qualification window.
      always_ff @(posedge sysclk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            ev_q      <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[b]};
            if (synced == deb_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_q <= '0;
               deb_q <= synced;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
            deb_dly_q <= deb_q;
            ev_q      <= deb_q & ~deb_dly_q;
         end
      end
   end

   logic [FTW_W-1:0] preset_tbl [NUM_PRESETS];

   for (genvar k = 0; k < NUM_PRESETS; k++) begin : g_tbl
      assign preset_tbl[k] = PRESETS[k*FTW_W +: FTW_W];
   end

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(NUM_PRESETS - 1)) ? '0 : i + IDX_W'(1);
   endfunction

   function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] i);
      return (i == '0) ? IDX_W'(NUM_PRESETS - 1) : i - IDX_W'(1);
   endfunction

   state_e           state_q, state_d;
   logic [FTW_W-1:0] freq_q,  freq_d;
   logic             ndr_q,   ndr_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic             pend_q,  pend_d;

   logic             ev_next, ev_prev, ev_clr;
   logic             step_req;
   logic [IDX_W-1:0] step_idx;

   assign ev_next  = press_ev[0];
   assign ev_prev  = press_ev[1];
   assign ev_clr   = press_ev[2];
   assign step_req = ev_next | ev_prev;
   assign step_idx = ev_next ? idx_inc(idx_q) : idx_dec(idx_q);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         freq_q  <= '0;
         ndr_q   <= 1'b0;
         idx_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         freq_q  <= freq_d;
         ndr_q   <= ndr_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
      end
   end

   // Handshake: NewDataReady marks FreqData valid. With HOLD_UNTIL_ACK=0 it is a one-cycle
   // pulse and the consumer must take it then; with HOLD_UNTIL_ACK=1 ready/data stay stable
   // in WAIT_ACK until a cycle where NewDataAck is high, which completes the transfer.
   // Presses arriving mid-transfer move the index and set a single pending flag; IDLE then
   // reissues the latest index, which guarantees NewDataReady drops for at least one cycle.
   always_comb begin
      state_d = state_q;
      freq_d  = freq_q;
      ndr_d   = ndr_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      if (ev_clr) begin
         state_d = IDLE;
         freq_d  = '0;
         ndr_d   = 1'b0;
         idx_d   = '0;
         pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (step_req) begin
                  idx_d   = step_idx;
                  freq_d  = preset_tbl[step_idx];
                  ndr_d   = 1'b1;
                  pend_d  = 1'b0;
                  state_d = ISSUE;
               end else if (pend_q) begin
                  freq_d  = preset_tbl[idx_q];
                  ndr_d   = 1'b1;
                  pend_d  = 1'b0;
                  state_d = ISSUE;
               end
            end
            ISSUE: begin
               if (step_req) begin
                  idx_d  = step_idx;
                  pend_d = 1'b1;
               end
               if (HOLD_UNTIL_ACK) begin
                  state_d = WAIT_ACK;
               end else begin
                  ndr_d   = 1'b0;
                  state_d = IDLE;
               end
            end
            WAIT_ACK: begin
               if (step_req) begin
                  idx_d  = step_idx;
                  pend_d = 1'b1;
               end
               if (NewDataAck) begin
                  ndr_d   = 1'b0;
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               ndr_d   = 1'b0;
            end
         endcase
      end
   end

   assign FreqData     = freq_q;
   assign NewDataReady = ndr_q;
   assign preset_idx   = idx_q;
   assign busy         = (state_q == WAIT_ACK);
   assign fsm_state_o  = state_q;

endmodule
